// File: rtl/input_conditioner_if.sv
// Button conditioner bus: raw levels and repeat enables in, debounced level and event pulses out.
interface input_conditioner_if #(
  parameter int N_BTN = 3
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] repeat_mask;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;
  logic             btn_any;

  modport master (
    output btn_raw, repeat_mask,
    input  btn_level, btn_press, btn_release, btn_repeat, btn_any
  );

  modport slave (
    input  btn_raw, repeat_mask,
    output btn_level, btn_press, btn_release, btn_repeat, btn_any
  );
endinterface

// File: rtl/input_conditioner.sv
// Per-channel synchronizer, debouncer, press/release edge pulses and optional autorepeat.
// Autorepeat logic is built only when INPUT_CONDITIONER_AUTOREPEAT_EN is defined.
module input_conditioner #(
  parameter int N_BTN         = 3,
  parameter int DEBOUNCE_CYC  = 250000,
  parameter int REPEAT_DELAY  = 5000000,
  parameter int REPEAT_PERIOD = 2500000
) (
  input logic               clk,
  input logic               rst,
  input_conditioner_if.slave bus
);
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] repeat_q, repeat_d;
  logic             any_q;
  logic [DB_W-1:0]  db_cnt_q [N_BTN];
  logic [DB_W-1:0]  db_cnt_d [N_BTN];

  // Two-flop synchronizer for the asynchronous raw levels
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= {N_BTN{1'b0}};
      sync2_q <= {N_BTN{1'b0}};
    end else begin
      sync1_q <= bus.btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce counters: level flips only after DEBOUNCE_CYC consecutive mismatching edges
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      db_cnt_d[i] = {DB_W{1'b0}};
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          level_d[i]  = ~level_q[i];
          db_cnt_d[i] = {DB_W{1'b0}};
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + {{(DB_W-1){1'b0}}, 1'b1};
        end
      end else begin
        db_cnt_d[i] = {DB_W{1'b0}};
      end
    end
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  // Debounced level and event pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= {N_BTN{1'b0}};
      press_q   <= {N_BTN{1'b0}};
      release_q <= {N_BTN{1'b0}};
      repeat_q  <= {N_BTN{1'b0}};
      any_q     <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt_q[i] <= {DB_W{1'b0}};
      end
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      any_q     <= |level_d;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  rpt_state_e       state_q   [N_BTN];
  rpt_state_e       state_d   [N_BTN];
  logic [RPT_W-1:0] rpt_cnt_q [N_BTN];
  logic [RPT_W-1:0] rpt_cnt_d [N_BTN];

  // Repeat FSM next state. The press-cycle counter load of 0 means DELAY reaches its
  // pulse at REPEAT_DELAY-2; a delay of 1 therefore fires straight from IDLE.
  // Looking at level_d lets a release suppress a pulse that would land on the release cycle.
  always_comb begin
    repeat_d = {N_BTN{1'b0}};
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i]   = state_q[i];
      rpt_cnt_d[i] = rpt_cnt_q[i];
      if (!level_d[i] || !bus.repeat_mask[i]) begin
        state_d[i]   = ST_IDLE;
        rpt_cnt_d[i] = {RPT_W{1'b0}};
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (press_q[i]) begin
              rpt_cnt_d[i] = {RPT_W{1'b0}};
              if (REPEAT_DELAY == 1) begin
                repeat_d[i] = 1'b1;
                state_d[i]  = ST_REPEAT;
              end else begin
                state_d[i]  = ST_DELAY;
              end
            end else begin
              state_d[i] = ST_IDLE;
            end
          end
          ST_DELAY: begin
            if (rpt_cnt_q[i] == RPT_W'(REPEAT_DELAY - 2)) begin
              repeat_d[i]  = 1'b1;
              state_d[i]   = ST_REPEAT;
              rpt_cnt_d[i] = {RPT_W{1'b0}};
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + {{(RPT_W-1){1'b0}}, 1'b1};
            end
          end
          ST_REPEAT: begin
            if (rpt_cnt_q[i] == RPT_W'(REPEAT_PERIOD - 1)) begin
              repeat_d[i]  = 1'b1;
              rpt_cnt_d[i] = {RPT_W{1'b0}};
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + {{(RPT_W-1){1'b0}}, 1'b1};
            end
          end
          default: begin
            state_d[i]   = ST_IDLE;
            rpt_cnt_d[i] = {RPT_W{1'b0}};
          end
        endcase
      end
    end
  end

  // Repeat FSM state and interval counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i]   <= ST_IDLE;
        rpt_cnt_q[i] <= {RPT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i]   <= state_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
    end
  end
`else
  logic unused_mask_s;
  assign unused_mask_s = ^bus.repeat_mask;
  assign repeat_d      = {N_BTN{1'b0}};
`endif

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.btn_repeat  = repeat_q;
  assign bus.btn_any     = any_q;
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 3, number of independent button channels (1..16).
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 250000, consecutive stable cycles required to accept a level change (>=1).
REQ-003 SHALL have parameter REPEAT_DELAY, default 5000000, cycles from press pulse to first repeat pulse (>=1).
REQ-004 SHALL have parameter REPEAT_PERIOD, default 2500000, cycles between subsequent repeat pulses (>=1).
REQ-005 SHALL have ports: clk  input  1  system clock, single domain.
REQ-006 SHALL have ports: rst  input  1  synchronous active-high reset.
REQ-007 SHALL have ports: btn_raw  input  N_BTN  asynchronous raw button levels, active-high.
REQ-008 SHALL have ports: repeat_mask  input  N_BTN  per-channel autorepeat enable, synchronous to clk.
REQ-009 SHALL have ports: btn_level  output  N_BTN  debounced level.
REQ-010 SHALL have ports: btn_press  output  N_BTN  one-cycle pulse on debounced 0->1.
REQ-011 SHALL have ports: btn_release  output  N_BTN  one-cycle pulse on debounced 1->0.
REQ-012 SHALL have ports: btn_repeat  output  N_BTN  one-cycle autorepeat pulse.
REQ-013 SHALL have ports: btn_any  output  1  OR of btn_level.

Function
REQ-014 Each btn_raw bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-015 Per channel, a counter of width $clog2(DEBOUNCE_CYC+1) SHALL increment on each edge where synchronized value != btn_level, and clear on any edge where they are equal.
REQ-016 When the counter is DEBOUNCE_CYC-1 and mismatch persists, btn_level SHALL toggle on that edge and the counter SHALL clear; total latency from first edge sampling a new stable raw value to btn_level change = DEBOUNCE_CYC+2 edges.
REQ-017 btn_press/btn_release SHALL assert in exactly the cycle btn_level first shows its new value, for one cycle.
REQ-018 Per-channel repeat FSM states: IDLE, DELAY, REPEAT; all outputs registered.
REQ-019 IDLE->DELAY on press with repeat_mask bit =1 (sampled in press cycle); counter loaded to 0.
REQ-020 DELAY: after REPEAT_DELAY cycles from press cycle, btn_repeat pulses one cycle, ->REPEAT.
REQ-021 REPEAT: btn_repeat pulses every REPEAT_PERIOD cycles after previous pulse.
REQ-022 Any state ->IDLE in the cycle btn_level goes 0 or repeat_mask bit goes 0; no repeat pulse in that cycle; release pulse unaffected.
REQ-023 Channels SHALL be fully independent; simultaneous events on multiple channels produce pulses in the same cycle.
REQ-024 btn_press and btn_repeat SHALL never assert together on the same channel.
REQ-025 Counters SHALL saturate-free: never wrap, since they clear on state change as above.

Reset
REQ-026 On rst=1 at a clk edge: synchronizers, debounce counters, btn_level, all pulse outputs, btn_any SHALL be 0 and FSMs SHALL be IDLE.
REQ-027 Reset mid-hold SHALL discard state; a raw input held high through reset SHALL produce a fresh press after DEBOUNCE_CYC+2 edges from rst deassertion.
REQ-028 No output SHALL pulse in the cycle rst is deasserted.

Configuration
REQ-029 Macro INPUT_CONDITIONER_AUTOREPEAT_EN defined: repeat FSMs and counters per REQ-018..022 are built.
REQ-030 Macro undefined: no repeat logic instantiated, btn_repeat SHALL be constant 0, repeat_mask ignored; all other behaviour unchanged.

Verification (N_BTN=3, DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, macro defined unless noted)
REQ-031 Clean press: btn_raw[0] 0->1 held -> btn_level[0]=1 and btn_press[0] pulse 6 edges later; release likewise gives btn_release[0] 6 edges after raw falls.
REQ-032 Bounce: btn_raw[1] toggles every 3 cycles for 30 cycles then settles 1 -> no output activity during bounce, one press 6 edges after final settle.
REQ-033 Autorepeat: repeat_mask=3'b001, btn_raw[0] held 40 cycles -> repeat pulses at press+10, +13, +16, ... ; none after release; repeat_mask cleared mid-hold stops pulses immediately.
REQ-034 Simultaneous: btn_raw=3'b111 at once -> btn_press=3'b111 in one cycle, btn_any=1 same cycle.
REQ-035 Reset mid-repeat: rst pulsed during REPEAT with raw held -> all outputs 0 next cycle, new press 6 edges after rst falls, first repeat 10 cycles later.
REQ-036 Macro undefined build: scenario REQ-033 -> btn_repeat stays 0, press/release timing identical.
